// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM state codes
// and serial line levels.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-time prescaler: bit_tick is high in the last clock of every bit time.
// Held at zero while clr is high so each frame starts on a full bit time.
module uart_tx_baud_gen #(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic bit_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign bit_tick = (cnt_r == LAST_CNT);

    // Prescale counter, wraps on every tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= ZERO_CNT;
        end else if (clr || bit_tick) begin
            cnt_r <= ZERO_CNT;
        end else begin
            cnt_r <= cnt_r + ONE_CNT;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding register, runtime
// parity and 1/2 stop bits; back-to-back frames leave no idle gap.
module uart_tx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy
);

    import uart_pkg::*;

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] ZERO_BIT = {BW{1'b0}};
    localparam logic [BW-1:0] ONE_BIT  = BW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                  state_r, state_s;
    logic [BW-1:0]           bit_cnt_r, bit_cnt_s;
    logic [DATA_WIDTH-1:0]   shift_r, shift_s;
    logic [DATA_WIDTH-1:0]   hold_data_r, hold_data_s;
    logic                    hold_full_r, hold_full_s;
    logic                    par_en_r, par_en_s;
    logic                    par_bit_r, par_bit_s;
    logic                    stop2_r, stop2_s;
    logic                    load_s, accept_s, tx_s, busy_s, bit_tick_s;

    uart_tx_baud_gen #(
        .PRESCALE (PRESCALE)
    ) u_baud (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (state_r == ST_IDLE),
        .bit_tick (bit_tick_s)
    );

    assign Data_Ready = ~hold_full_r;
    assign accept_s   = Data_Valid && ~hold_full_r;

    // Frame sequencing; the bit counter doubles as the stop-bit counter.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    state_s   = ST_START;
                    bit_cnt_s = ZERO_BIT;
                    load_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = ZERO_BIT;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s && (bit_cnt_r == LAST_BIT)) begin
                    state_s   = par_en_r ? ST_PARITY : ST_STOP;
                    bit_cnt_s = ZERO_BIT;
                end else if (bit_tick_s) begin
                    bit_cnt_s = bit_cnt_r + ONE_BIT;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_tick_s) begin
                    state_s   = ST_STOP;
                    bit_cnt_s = ZERO_BIT;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_tick_s && stop2_r && (bit_cnt_r == ZERO_BIT)) begin
                    bit_cnt_s = ONE_BIT;
                end else if (bit_tick_s && hold_full_r) begin
                    state_s   = ST_START;
                    bit_cnt_s = ZERO_BIT;
                    load_s    = 1'b1;
                end else if (bit_tick_s) begin
                    state_s   = ST_IDLE;
                    bit_cnt_s = ZERO_BIT;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = ZERO_BIT;
            end
        endcase
    end

    // Holding register, shifter and per-frame configuration snapshot.
    always_comb begin
        hold_data_s = accept_s ? P_DATA : hold_data_r;
        if (accept_s) begin
            hold_full_s = 1'b1;
        end else if (load_s) begin
            hold_full_s = 1'b0;
        end else begin
            hold_full_s = hold_full_r;
        end

        if (load_s) begin
            shift_s   = hold_data_r;
            par_en_s  = PAR_EN;
            par_bit_s = (^hold_data_r) ^ PAR_TYP;
            stop2_s   = STOP2;
        end else if ((state_r == ST_DATA) && bit_tick_s) begin
            shift_s   = {1'b0, shift_r[DATA_WIDTH-1:1]};
            par_en_s  = par_en_r;
            par_bit_s = par_bit_r;
            stop2_s   = stop2_r;
        end else begin
            shift_s   = shift_r;
            par_en_s  = par_en_r;
            par_bit_s = par_bit_r;
            stop2_s   = stop2_r;
        end

        case (state_s)
            ST_START:  tx_s = START_BIT;
            ST_DATA:   tx_s = shift_s[0];
            ST_PARITY: tx_s = par_bit_s;
            ST_STOP:   tx_s = STOP_BIT;
            default:   tx_s = IDLE_LVL;
        endcase

        busy_s = (state_s != ST_IDLE) || hold_full_s;
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= ZERO_BIT;
            shift_r     <= {DATA_WIDTH{1'b0}};
            hold_data_r <= {DATA_WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            par_en_r    <= 1'b0;
            par_bit_r   <= 1'b0;
            stop2_r     <= 1'b0;
            TX_OUT      <= IDLE_LVL;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            hold_data_r <= hold_data_s;
            hold_full_r <= hold_full_s;
            par_en_r    <= par_en_s;
            par_bit_r   <= par_bit_s;
            stop2_r     <= stop2_s;
            TX_OUT      <= tx_s;
            busy        <= busy_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: default 8-bit/PRESCALE=1 instance plus a
// 7-bit/PRESCALE=4 instance. Inputs change and outputs are sampled on negedge.
module tb_uart_tx_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_tx, a_busy;
    logic [6:0] b_data;
    logic       b_valid, b_ready, b_tx, b_busy;
    logic       par_en, par_typ, stop2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        s2;
        int          len;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    always #5 CLK = ~CLK;

    uart_tx_param dut (
        .CLK(CLK), .RST(RST), .P_DATA(a_data), .Data_Valid(a_valid),
        .Data_Ready(a_ready), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .TX_OUT(a_tx), .busy(a_busy)
    );

    uart_tx_param #(.DATA_WIDTH(7), .PRESCALE(4)) dut_p4 (
        .CLK(CLK), .RST(RST), .P_DATA(b_data), .Data_Valid(b_valid),
        .Data_Ready(b_ready), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .TX_OUT(b_tx), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame on the default instance; expected bits are in line order.
    task automatic send_frame(input string name, input logic [7:0] d, input logic pe,
                              input logic pt, input logic s2, input int len,
                              input logic [15:0] exp, input int flip_at);
        logic [15:0] obs;
        int busy_hi;
        obs = 16'h0000;
        busy_hi = 0;
        @(negedge CLK);
        a_data = d; par_en = pe; par_typ = pt; stop2 = s2; a_valid = 1'b1;
        @(negedge CLK);
        a_valid = 1'b0;
        a_data  = ~d;
        chk({name, "_lat_tx"}, 64'(a_tx), 64'(1));
        chk({name, "_lat_busy"}, 64'(a_busy), 64'(1));
        chk({name, "_lat_ready"}, 64'(a_ready), 64'(0));
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            obs = {obs[14:0], a_tx};
            if (a_busy) busy_hi++;
            if (i == flip_at) par_typ = ~par_typ;
        end
        chk({name, "_frame"}, 64'(obs), 64'(exp));
        chk({name, "_busy_cycles"}, 64'(busy_hi), 64'(len));
        @(negedge CLK);
        chk({name, "_end_tx"}, 64'(a_tx), 64'(1));
        chk({name, "_end_busy"}, 64'(a_busy), 64'(0));
        chk({name, "_end_ready"}, 64'(a_ready), 64'(1));
    endtask

    initial begin
        logic [21:0] b2b_obs;
        logic [23:0] rdy_obs;
        int          b2b_busy;
        logic [35:0] p4_obs, p4_exp;
        logic [8:0]  p4_bits;
        int          p4_busy;
        int          idle_bad;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 16'b0000_0001_0100_1011};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 11, 16'b0000_0011_1000_0011};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 11, 16'b0000_0011_1000_0001};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 11, 16'b0000_0010_1001_0111};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 12, 16'b0000_0000_0000_0111};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b1, 12, 16'b0000_0001_1110_0011};

        RST = 1'b1;
        a_data = 8'h00; a_valid = 1'b0;
        b_data = 7'h00; b_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        #12;
        chk("rst_tx", 64'(a_tx), 64'(1));
        chk("rst_busy", 64'(a_busy), 64'(0));
        chk("rst_ready", 64'(a_ready), 64'(1));
        chk("rst_p4_tx", 64'(b_tx), 64'(1));
        chk("rst_p4_ready", 64'(b_ready), 64'(1));
        @(negedge CLK);
        RST = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].pe, vecs[v].pt,
                       vecs[v].s2, vecs[v].len, vecs[v].exp, -1);
        end

        // PAR_TYP flips mid-DATA: this frame stays even, the next one is odd.
        send_frame("flip_cur", 8'h07, 1'b1, 1'b0, 1'b0, 11, 16'b0000_0011_1000_0011, 4);
        chk("flip_latched", 64'(par_typ), 64'(1));
        send_frame("flip_next", 8'h07, 1'b1, par_typ, 1'b0, 11, 16'b0000_0011_1000_0001, -1);

        // Back-to-back 55 then AA with two stop bits.
        b2b_obs = 22'h0; rdy_obs = 24'h0; b2b_busy = 0;
        @(negedge CLK);
        a_data = 8'h55; par_en = 1'b0; stop2 = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            rdy_obs = {rdy_obs[22:0], a_ready};
            if (i >= 1 && i <= 22) b2b_obs = {b2b_obs[20:0], a_tx};
            if (i <= 22 && a_busy) b2b_busy++;
            if (i == 23) chk("b2b_end_busy", 64'(a_busy), 64'(0));
            if (i == 0) a_data = 8'hAA;
            if (i == 2) a_valid = 1'b0;
        end
        chk("b2b_frames", 64'(b2b_obs), 64'({11'b01010101011, 11'b00101010111}));
        chk("b2b_ready", 64'(rdy_obs), 64'(24'b0100_0000_0000_1111_1111_1111));
        chk("b2b_busy_cycles", 64'(b2b_busy), 64'(23));
        stop2 = 1'b0;

        // PRESCALE=4, 7-bit 41: nine bits of four cycles each.
        p4_bits = 9'b010000011;
        p4_exp = 36'h0; p4_obs = 36'h0; p4_busy = 0;
        for (int j = 0; j < 36; j++) p4_exp = {p4_exp[34:0], p4_bits[8 - j / 4]};
        @(negedge CLK);
        b_data = 7'h41; b_valid = 1'b1;
        @(negedge CLK);
        b_valid = 1'b0;
        chk("p4_lat_tx", 64'(b_tx), 64'(1));
        for (int j = 0; j < 36; j++) begin
            @(negedge CLK);
            p4_obs = {p4_obs[34:0], b_tx};
            if (b_busy) p4_busy++;
        end
        chk("p4_frame", 64'(p4_obs), 64'(p4_exp));
        chk("p4_busy_cycles", 64'(p4_busy), 64'(36));
        @(negedge CLK);
        chk("p4_end_busy", 64'(b_busy), 64'(0));
        chk("p4_end_tx", 64'(b_tx), 64'(1));

        // Reset in mid-DATA of an all-zero frame with a second word held.
        @(negedge CLK);
        a_data = 8'h00; a_valid = 1'b1;
        @(negedge CLK);
        a_data = 8'h3C;
        @(negedge CLK);
        @(negedge CLK);
        a_valid = 1'b0;
        @(negedge CLK);
        chk("pre_rst_tx", 64'(a_tx), 64'(0));
        chk("pre_rst_ready", 64'(a_ready), 64'(0));
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_tx", 64'(a_tx), 64'(1));
        chk("mid_rst_busy", 64'(a_busy), 64'(0));
        chk("mid_rst_ready", 64'(a_ready), 64'(1));
        @(negedge CLK);
        RST = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (a_tx !== 1'b1 || a_busy !== 1'b0) idle_bad++;
        end
        chk("post_rst_idle", 64'(idle_bad), 64'(0));
        send_frame("post_rst", vecs[0].data, vecs[0].pe, vecs[0].pt, vecs[0].s2,
                   vecs[0].len, vecs[0].exp, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
